branch_issue_arbiter: RTL and testbench
=======================================

BRANCH_ISSUE_ARBITER -- requirements
Module: branch_issue_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): addressWidth, 64, instruction address width; instructionCounterWidth, 64, major ID width; PidSize, 20, process ID width; TidSize, 16, thread ID width; bodyWidth, 28, branch body width (BO, BI, BD with 2 appended zero bits, AA, LK); QueueDepth, 4, entries per lane queue (power of two, at least 2).
REQ-002 P SHALL denote the payload width: 6 + addressWidth + instructionCounterWidth + PidSize + TidSize + 1 + bodyWidth, packed MSB-first as opcode, address, majId, pid, tid, is64Bit, body.
REQ-003 clock_i  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  synchronous pipeline flush.
REQ-006 lane0Valid_i, lane1Valid_i  input  1 each  decoded branch present on that lane.
REQ-007 lane0Data_i, lane1Data_i  input  P each  decoded branch payload.
REQ-008 lane0Stall_o, lane1Stall_o  output  1 each  lane queue full; the decoder holds its output.
REQ-009 issueValid_o  output  1  issue register holds a branch.
REQ-010 issueReady_i  input  1  branch unit accepts this cycle.
REQ-011 issueData_o  output  P  payload of the issued branch.
REQ-012 issueLane_o  output  1  source lane of the issued branch.
REQ-013 issuedCount_o  output  32  count of accepted issues.

Function
REQ-014 Each lane SHALL own a FIFO of QueueDepth entries with read pointer, write pointer and occupancy count; pointers wrap modulo QueueDepth.
REQ-015 laneNStall_o SHALL be driven combinationally from the registered count and assert exactly when count == QueueDepth.
REQ-016 A push SHALL occur when laneNValid_i == 1 and laneNStall_o == 0; a valid on a full lane is ignored, with no queue state change.
REQ-017 Full lane: a pop and an offered push in the same cycle SHALL result in no push; the lane is stalled from the registered count.
REQ-018 Non-full lane: a pop and a push in the same cycle SHALL both occur, leaving the count unchanged.
REQ-019 The issue register SHALL be loadable when issueValid_o == 0 or when (issueValid_o && issueReady_i) is true.
REQ-020 When loadable and at least one queue is non-empty, the arbiter SHALL pop exactly one head into the issue register that cycle.
REQ-021 Selection: with one non-empty queue, that head is taken; with both non-empty, the head with the smaller majId (unsigned) is taken.
REQ-022 With both non-empty and equal majIds, the lane named by rrPtr SHALL win; rrPtr then toggles to the other lane.
REQ-023 rrPtr SHALL change only on a tie.
REQ-024 When loadable and both queues are empty, issueValid_o SHALL become 0 on the next edge.
REQ-025 issueData_o and issueLane_o SHALL hold stable while issueValid_o == 1 and issueReady_i == 0.
REQ-026 Latency: a push at edge N into empty queues with an empty issue register SHALL give issueValid_o == 1 after edge N+1; there is no same-cycle bypass from input to output.
REQ-027 Sustained throughput SHALL be one issue per cycle while issueReady_i == 1 and a queue is non-empty.
REQ-028 issuedCount_o SHALL increment by 1 on each edge with issueValid_o && issueReady_i, wrapping from 0xFFFFFFFF to 0.
REQ-029 flush_i == 1 SHALL clear both queues' pointers and counts and clear issueValid_o on the next edge.
REQ-030 During a flush cycle, same-cycle pushes SHALL be discarded.
REQ-031 A handshake in a flush cycle SHALL still increment issuedCount_o; rrPtr and issuedCount_o are otherwise unaffected by flush.
REQ-032 Queue storage contents SHALL not require reset or flush clearing.

Reset
REQ-033 While reset_i == 0, independent of clock: both queues empty (pointers and counts 0), issueValid_o = 0, issueLane_o = 0, issueData_o = 0, rrPtr = 0 (lane 0), issuedCount_o = 0.
REQ-034 Consequently, during reset both stall outputs SHALL read 0.
REQ-035 Reset asserted mid-transfer SHALL drop any held issue and all queued entries; a handshake on a reset edge is not counted.
REQ-036 The first rising edge after reset_i returns to 1 SHALL be a normal operating edge.

Verification
REQ-037 Lane0 pushes majId 5 at cycle 0 with issueReady_i = 1 -> issueValid_o = 1, issueData_o majId = 5, issueLane_o = 0 in cycle 1; issuedCount_o = 1 after cycle 1.
REQ-038 Both lanes push together (lane0 majId 9, lane1 majId 7), issueReady_i = 1 -> issue order 7 (lane1) then 9 (lane0).
REQ-039 Both lanes push majId 3 repeatedly for 4 cycles from reset -> issueLane_o sequence 0,1,0,1; rrPtr alternates.
REQ-040 issueReady_i = 0, lane0 pushes 6 entries -> lane0Stall_o asserts with 1 held in the issue register and 4 queued; 6th push ignored; after ready the majIds drain in order and count = 5.
REQ-041 Queues holding 3 entries, issueValid_o = 1, flush_i pulse with a simultaneous lane1 push -> next cycle issueValid_o = 0, stalls 0, no further issues.
REQ-042 issuedCount_o preloaded to 0xFFFFFFFF by 2^32-1 accepted issues (or forced), then 1 accept -> issuedCount_o = 0; reset_i low mid-stream -> all outputs immediately at reset values.

Source files
------------

// File: rtl/branch_issue_arbiter.sv
// Two-lane branch issue arbiter: per-lane FIFOs feed one issue register.
// Picks the oldest majId head each cycle; equal majIds alternate via rrPtr.
//
// Ports:
//   clock_i, reset_i (async active-low), flush_i
//   laneNValid_i / laneNData_i : decoded branch per lane
//   laneNStall_o               : lane queue full
//   issueValid_o / issueReady_i: issue handshake
//   issueData_o / issueLane_o  : issued payload and its lane
//   issuedCount_o              : accepted issue count (wraps)
module branch_issue_arbiter #(
  parameter int addressWidth = 64,
  parameter int instructionCounterWidth = 64,
  parameter int PidSize = 20,
  parameter int TidSize = 16,
  parameter int bodyWidth = 28,
  parameter int QueueDepth = 4,
  localparam int P = 6 + addressWidth
                   + instructionCounterWidth
                   + PidSize + TidSize + 1
                   + bodyWidth
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         lane0Valid_i,
  input  logic [P-1:0] lane0Data_i,
  input  logic         lane1Valid_i,
  input  logic [P-1:0] lane1Data_i,
  output logic         lane0Stall_o,
  output logic         lane1Stall_o,
  output logic         issueValid_o,
  input  logic         issueReady_i,
  output logic [P-1:0] issueData_o,
  output logic         issueLane_o,
  output logic [31:0]  issuedCount_o
);

  localparam int ML = PidSize + TidSize
                    + 1 + bodyWidth;
  localparam int MW = instructionCounterWidth;
  localparam int AW = $clog2(QueueDepth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL =
    CW'(QueueDepth);

  logic [P-1:0]  mem_q [2][QueueDepth];
  logic [AW-1:0] rd_q [2];
  logic [AW-1:0] rd_d [2];
  logic [AW-1:0] wr_q [2];
  logic [AW-1:0] wr_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [P-1:0]  din [2];
  logic [P-1:0]  head [2];

  logic [1:0]    vld, full, ne, push, pop;
  logic [MW-1:0] maj0, maj1;
  logic          load, sel, tie;

  logic          vld_q, vld_d;
  logic [P-1:0]  data_q, data_d;
  logic          lane_q, lane_d;
  logic          rr_q, rr_d;
  logic [31:0]   issued_q, issued_d;

  assign vld     = {lane1Valid_i, lane0Valid_i};
  assign din[0]  = lane0Data_i;
  assign din[1]  = lane1Data_i;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      full[l] = (cnt_q[l] == FULL);
      ne[l]   = (cnt_q[l] != '0);
      head[l] = mem_q[l][rd_q[l]];
    end
  end

  assign lane0Stall_o  = full[0];
  assign lane1Stall_o  = full[1];
  assign issueValid_o  = vld_q;
  assign issueData_o   = data_q;
  assign issueLane_o   = lane_q;
  assign issuedCount_o = issued_q;

  always_comb begin
    load = !vld_q || issueReady_i;
    maj0 = head[0][ML +: MW];
    maj1 = head[1][ML +: MW];
    sel  = 1'b0;
    tie  = 1'b0;
    unique case (1'b1)
      (&ne && maj0 < maj1): sel = 1'b0;
      (&ne && maj1 < maj0): sel = 1'b1;
      (&ne && maj0 == maj1): begin
        sel = rr_q;
        tie = 1'b1;
      end
      (ne == 2'b10): sel = 1'b1;
      default:       sel = 1'b0;
    endcase
  end

  always_comb begin
    pop  = '0;
    push = vld & ~full & {2{~flush_i}};
    if (load && !flush_i && |ne)
      pop[sel] = 1'b1;
    for (int l = 0; l < 2; l++) begin
      rd_d[l]  = rd_q[l] + AW'(pop[l]);
      wr_d[l]  = wr_q[l] + AW'(push[l]);
      cnt_d[l] = cnt_q[l]
               + CW'(push[l])
               - CW'(pop[l]);
      if (flush_i) begin
        rd_d[l]  = '0;
        wr_d[l]  = '0;
        cnt_d[l] = '0;
      end
    end
  end

  always_comb begin
    vld_d    = vld_q;
    data_d   = data_q;
    lane_d   = lane_q;
    rr_d     = rr_q;
    issued_d = issued_q
             + 32'(vld_q & issueReady_i);
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = |ne;
      if (|ne) begin
        data_d = head[sel];
        lane_d = sel;
      end
      // rrPtr moves only when a tie decided the pick
      if (tie)
        rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int l = 0; l < 2; l++) begin
        rd_q[l]  <= '0;
        wr_q[l]  <= '0;
        cnt_q[l] <= '0;
      end
      vld_q    <= 1'b0;
      data_q   <= '0;
      lane_q   <= 1'b0;
      rr_q     <= 1'b0;
      issued_q <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        rd_q[l]  <= rd_d[l];
        wr_q[l]  <= wr_d[l];
        cnt_q[l] <= cnt_d[l];
      end
      vld_q    <= vld_d;
      data_q   <= data_d;
      lane_q   <= lane_d;
      rr_q     <= rr_d;
      issued_q <= issued_d;
    end
  end

  // Storage is qualified by the counts, so it needs no reset.
  always_ff @(posedge clock_i) begin
    for (int l = 0; l < 2; l++)
      if (push[l])
        mem_q[l][wr_q[l]] <= din[l];
  end

endmodule

// File: tb/tb_branch_issue_arbiter.sv
// Bench for branch_issue_arbiter: directed scenarios then random
// traffic, checked against a queue-based reference model.
module tb_branch_issue_arbiter;

  localparam int AW = 64;
  localparam int ICW = 64;
  localparam int PS = 20;
  localparam int TS = 16;
  localparam int BW = 28;
  localparam int QD = 4;
  localparam int P = 6 + AW + ICW + PS + TS + 1 + BW;
  localparam int ML = PS + TS + 1 + BW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic v0 = 1'b0;
  logic v1 = 1'b0;
  logic rdy = 1'b0;
  logic [P-1:0] d0 = '0;
  logic [P-1:0] d1 = '0;
  logic s0, s1, iv, il;
  logic [P-1:0] idata;
  logic [31:0] icnt;

  branch_issue_arbiter dut (
    .clock_i(clk),
    .reset_i(rst_n),
    .flush_i(flush),
    .lane0Valid_i(v0),
    .lane0Data_i(d0),
    .lane1Valid_i(v1),
    .lane1Data_i(d1),
    .lane0Stall_o(s0),
    .lane1Stall_o(s1),
    .issueValid_o(iv),
    .issueReady_i(rdy),
    .issueData_o(idata),
    .issueLane_o(il),
    .issuedCount_o(icnt)
  );

  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail = 0;

  logic [P-1:0] q0[$];
  logic [P-1:0] q1[$];
  bit mValid;
  logic [P-1:0] mData;
  bit mLane;
  bit mRr;
  logic [31:0] mCnt;

  function automatic logic [P-1:0] mk(input logic [63:0] maj);
    logic [P-1:0] p;
    for (int i = 0; i < P; i++) p[i] = 1'($urandom_range(1, 0));
    p[ML +: ICW] = maj;
    return p;
  endfunction

  function automatic logic [63:0] majOf(input logic [P-1:0] p);
    return p[ML +: ICW];
  endfunction

  task automatic chk(input string tag, input logic [P-1:0] obs,
                     input logic [P-1:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    mValid = 0;
    mData = '0;
    mLane = 0;
    mRr = 0;
    mCnt = '0;
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_edge();
    bit full0, full1;
    int pick;
    full0 = (q0.size() == QD);
    full1 = (q1.size() == QD);
    pick = -1;
    if (mValid && rdy) mCnt = mCnt + 1;
    if (flush) begin
      q0.delete();
      q1.delete();
      mValid = 0;
    end else begin
      if (!mValid || rdy) begin
        if (q0.size() > 0 && q1.size() > 0) begin
          if (majOf(q0[0]) < majOf(q1[0])) pick = 0;
          else if (majOf(q1[0]) < majOf(q0[0])) pick = 1;
          else begin
            pick = int'(mRr);
            mRr = !mRr;
          end
        end else if (q0.size() > 0) pick = 0;
        else if (q1.size() > 0) pick = 1;
        if (pick == 0) begin
          mData = q0.pop_front();
          mValid = 1;
          mLane = 0;
        end else if (pick == 1) begin
          mData = q1.pop_front();
          mValid = 1;
          mLane = 1;
        end else begin
          mValid = 0;
        end
      end
      if (v0 && !full0) q0.push_back(d0);
      if (v1 && !full1) q1.push_back(d1);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, P'(iv), P'(mValid));
    chk({tag, ".stall0"}, P'(s0), P'(q0.size() == QD));
    chk({tag, ".stall1"}, P'(s1), P'(q1.size() == QD));
    chk({tag, ".count"}, P'(icnt), P'(mCnt));
    if (mValid) begin
      chk({tag, ".data"}, idata, mData);
      chk({tag, ".lane"}, P'(il), P'(mLane));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    v0 = 0;
    v1 = 0;
    flush = 0;
    rst_n = 0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst.valid", P'(iv), P'(0));
    chk("rst.data", idata, P'(0));
    chk("rst.lane", P'(il), P'(0));
    chk("rst.count", P'(icnt), P'(0));
    chk("rst.stall0", P'(s0), P'(0));
    chk("rst.stall1", P'(s1), P'(0));
    @(posedge clk);
    #1;
    rst_n = 1;

    // single lane0 branch, majId 5
    v0 = 1; d0 = mk(5); rdy = 1;
    step("s1a");
    v0 = 0;
    step("s1b");
    chk("s1.valid", P'(iv), P'(1));
    chk("s1.maj", P'(majOf(idata)), P'(5));
    chk("s1.lane", P'(il), P'(0));
    step("s1c");
    chk("s1.count", P'(icnt), P'(1));

    // older majId wins across lanes
    v0 = 1; d0 = mk(9); v1 = 1; d1 = mk(7);
    step("s2a");
    v0 = 0; v1 = 0;
    step("s2b");
    chk("s2.maj1st", P'(majOf(idata)), P'(7));
    chk("s2.lane1st", P'(il), P'(1));
    step("s2c");
    chk("s2.maj2nd", P'(majOf(idata)), P'(9));
    chk("s2.lane2nd", P'(il), P'(0));
    step("s2d");

    // equal majIds alternate lanes starting at lane 0
    do_reset();
    rdy = 1;
    for (int i = 0; i < 10; i++) begin
      v0 = (i < 4); v1 = (i < 4);
      d0 = mk(3); d1 = mk(3);
      step("s3");
      if (i >= 1 && i <= 4)
        chk("s3.rrlane", P'(il), P'((i - 1) % 2));
    end
    v0 = 0; v1 = 0;

    // lane0 fills with ready low
    rdy = 0;
    for (int i = 0; i < 6; i++) begin
      v0 = 1; d0 = mk(64'(10 + i));
      step("s4fill");
    end
    v0 = 0;
    chk("s4.stall0", P'(s0), P'(1));
    chk("s4.held", P'(majOf(idata)), P'(10));
    rdy = 1;
    for (int k = 0; k < 5; k++) begin
      chk("s4.order", P'(majOf(idata)), P'(10 + k));
      step("s4drain");
    end
    chk("s4.count", P'(icnt), P'(13));
    chk("s4.empty", P'(iv), P'(0));

    // flush with queued entries and a colliding push
    rdy = 0;
    for (int i = 0; i < 2; i++) begin
      v0 = 1; v1 = 1; d0 = mk(20); d1 = mk(21);
      step("s5fill");
    end
    chk("s5.held", P'(iv), P'(1));
    v0 = 0; v1 = 1; d1 = mk(22); flush = 1;
    step("s5flush");
    flush = 0; v1 = 0;
    chk("s5.valid", P'(iv), P'(0));
    chk("s5.stall0", P'(s0), P'(0));
    chk("s5.stall1", P'(s1), P'(0));
    rdy = 1;
    for (int i = 0; i < 3; i++) begin
      step("s5idle");
      chk("s5.noissue", P'(iv), P'(0));
    end

    // counter wrap
    rdy = 0;
    force dut.issued_q = 32'hFFFF_FFFF;
    #1;
    release dut.issued_q;
    mCnt = 32'hFFFF_FFFF;
    chk("s6.preload", P'(icnt), P'(32'hFFFF_FFFF));
    rdy = 1; v0 = 1; d0 = mk(1);
    step("s6a");
    v0 = 0;
    step("s6b");
    step("s6c");
    chk("s6.wrap", P'(icnt), P'(0));

    // reset mid-stream
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      v0 = 1; v1 = 1; d0 = mk(30); d1 = mk(31);
      step("s7fill");
    end
    v0 = 0; v1 = 0;
    rst_n = 0;
    #1;
    model_reset();
    chk("s7.valid", P'(iv), P'(0));
    chk("s7.data", idata, P'(0));
    chk("s7.lane", P'(il), P'(0));
    chk("s7.count", P'(icnt), P'(0));
    chk("s7.stall0", P'(s0), P'(0));
    chk("s7.stall1", P'(s1), P'(0));
    @(posedge clk);
    #1;
    rst_n = 1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      v0 = ($urandom_range(3, 0) != 0);
      v1 = ($urandom_range(3, 0) != 0);
      d0 = mk(64'($urandom_range(3, 0)));
      d1 = mk(64'($urandom_range(3, 0)));
      if (i < 300) rdy = ($urandom_range(1, 0) != 0);
      else rdy = ($urandom_range(3, 0) != 0);
      flush = ($urandom_range(39, 0) == 0);
      step("rnd");
    end
    flush = 0; v0 = 0; v1 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
